key_debouncer: RTL
==================

Name: key_debouncer

Overview:
- Upstream conditioning stage for the 8 board push-buttons.
- Takes raw, asynchronous, active-low, bouncing key pins and synchronises and debounces each one.
- Drives the clean active-low vector into the key read port. Inversion to active-high stays downstream.
- Also produces per-key press/release pulses and sticky press flags, which the CPU can poll and clear.

Parameters:
- WIDTH, 8, number of keys.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a change (10 ms at 50 MHz). Legal range is 2 to 2^CNT_W-1.
- CNT_W, 20, width of each per-key stability counter.

Ports:
- clk  input  1  system clock; the single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- key_raw  input  WIDTH  raw key pins; active-low (0 = pressed); asynchronous to clk.
- key_db  output  WIDTH  debounced key level; active-low; feeds the key read port.
- press_pulse  output  WIDTH  one-cycle high when a key's debounced level goes 1->0.
- release_pulse  output  WIDTH  one-cycle high when a key's debounced level goes 0->1.
- press_flag  output  WIDTH  sticky per-key "pressed since last clear".
- flag_clr  input  WIDTH  per-bit clear mask for press_flag; sampled every cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both synchroniser stages go to all-ones.
  - key_db goes to all-ones (released).
  - All counters go to 0.
  - press_pulse, release_pulse and press_flag go to 0.
  - Reset asserted mid-debounce discards the partial count. There is no spurious pulse on reset release.
- Synchroniser:
  - Two flops per bit: s1 <= key_raw, s2 <= s1.
  - Only s2 is used downstream.
- Per-key debounce, each bit independent:
  - If s2 == key_db[i], cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1, then key_db[i] <= s2 and cnt[i] <= 0.
  - Else cnt[i] <= cnt[i]+1.
  - Any return of s2 to the current key_db value before acceptance restarts the count. This rejects bounces shorter than DEBOUNCE_CYCLES cycles.
- Latency:
  - A clean step on key_raw that is sampled at edge E appears on key_db at edge E+1+DEBOUNCE_CYCLES.
  - That is 2 synchroniser cycles plus DEBOUNCE_CYCLES-1 counting cycles.
- Counter behaviour:
  - Counters saturate by construction and never wrap.
  - CNT_W must hold DEBOUNCE_CYCLES-1; this is an elaboration check.
- Pulses:
  - press_pulse[i] is registered and is high for exactly the cycle after key_db[i] falls.
  - release_pulse[i] follows the same rule for a rise.
  - The two are never high together on the same bit.
- press_flag:
  - press_flag[i] is set on the cycle press_pulse[i] goes high.
  - It is cleared when flag_clr[i] is high.
  - If set and clear coincide, set wins and the flag stays 1, so a press is never lost.
  - Clearing one bit does not affect the others.
- Simultaneity:
  - Multiple keys may change in the same cycle.
  - Each bit is processed independently with no priority between bits.
- Output type: all outputs are registered; there is no combinational path from input to output.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset:
  - Stimulus: hold rst_n=0 with key_raw=8'h00, then release.
  - Required: key_db=8'hFF, pulses=0 and flags=0 during reset. key_db falls to 8'h00 exactly 5 edges after the first sampling edge. press_pulse=8'hFF for exactly one cycle; press_flag=8'hFF.
- Clean press:
  - Stimulus: key_raw[0] goes 1->0 at edge E.
  - Required: key_db[0]=0 at E+5 and no earlier. press_pulse[0]=1 during E+5..E+6 only. press_flag[0]=1. Other bits are unchanged.
- Bounce rejection:
  - Stimulus: key_raw[3] toggles 0,1,0,1 with 3-cycle glitches, then settles at 1.
  - Required: key_db[3] stays 1 throughout. No press_pulse or release_pulse on bit 3.
- Release and flag clear:
  - Stimulus: after the clean press, release key 0; then drive flag_clr=8'h01 for one cycle.
  - Required: release_pulse[0] is a single cycle. press_flag[0] is still 1 until the clear, then 0. press_flag of other bits is unaffected.
- Set/clear collision:
  - Stimulus: flag_clr[5]=1 held on the same cycle press_pulse[5] asserts.
  - Required: press_flag[5]=1 afterwards.
- Mid-debounce reset:
  - Stimulus: key_raw[7] goes low; rst_n pulses low for 1 cycle at count 2.
  - Required: key_db[7]=1 immediately. The count restarts, and the key is accepted 5 edges after reset release with key_raw held low.

Source files
------------

// File: rtl/key_debouncer_if.sv
// Key bus between the raw board pins / CPU side and the debouncer.
// master is the debouncer itself; slave is the pin driver and key read port.
interface key_debouncer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] key_raw;
    logic [WIDTH-1:0] flag_clr;
    logic [WIDTH-1:0] key_db;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;
    logic [WIDTH-1:0] press_flag;

    modport master (
        input  key_raw,
        input  flag_clr,
        output key_db,
        output press_pulse,
        output release_pulse,
        output press_flag
    );

    modport slave (
        output key_raw,
        output flag_clr,
        input  key_db,
        input  press_pulse,
        input  release_pulse,
        input  press_flag
    );
endinterface

// File: rtl/key_debouncer.sv
// Per-key two-flop synchroniser and stability-count debouncer for active-low push-buttons,
// with registered press/release pulses and CPU-clearable sticky press flags.
module key_debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input logic             clk,
    input logic             rst_n,
    key_debouncer_if.master kb
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if ((DEBOUNCE_CYCLES < 2) ||
        (longint'(DEBOUNCE_CYCLES) - 1 > (longint'(1) << CNT_W) - 1)) begin : g_bad_cfg
        $error("key_debouncer: DEBOUNCE_CYCLES-1 must fit in CNT_W bits and be >= 1");
    end

    logic [WIDTH-1:0] key_s1_p0;
    logic [WIDTH-1:0] key_s2_p1;
    logic [WIDTH-1:0] key_db_p2;
    logic [WIDTH-1:0] db_next;
    logic [WIDTH-1:0] press_pulse_p2;
    logic [WIDTH-1:0] release_pulse_p2;
    logic [WIDTH-1:0] press_flag_p2;
    logic [WIDTH-1:0] press_set;
    logic [CNT_W-1:0] cnt_p2   [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];

    // Stage p2: a bit only moves once s2 has disagreed with it for DEBOUNCE_CYCLES edges
    always_comb begin
        db_next = key_db_p2;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (key_s2_p1[i] != key_db_p2[i]) begin
                if (cnt_p2[i] == CNT_LAST) begin
                    db_next[i] = key_s2_p1[i];
                end else begin
                    cnt_next[i] = cnt_p2[i] + 1'b1;
                end
            end
        end
    end

    // Holding the set term for the whole pulse cycle lets a press win over a clear either edge
    assign press_set = (key_db_p2 & ~db_next) | press_pulse_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_p0        <= '1;
            key_s2_p1        <= '1;
            key_db_p2        <= '1;
            cnt_p2           <= '{default: '0};
            press_pulse_p2   <= '0;
            release_pulse_p2 <= '0;
            press_flag_p2    <= '0;
        end else begin
            key_s1_p0        <= kb.key_raw;
            key_s2_p1        <= key_s1_p0;
            key_db_p2        <= db_next;
            cnt_p2           <= cnt_next;
            press_pulse_p2   <= key_db_p2 & ~db_next;
            release_pulse_p2 <= ~key_db_p2 & db_next;
            press_flag_p2    <= (press_flag_p2 & ~kb.flag_clr) | press_set;
        end
    end

    assign kb.key_db        = key_db_p2;
    assign kb.press_pulse   = press_pulse_p2;
    assign kb.release_pulse = release_pulse_p2;
    assign kb.press_flag    = press_flag_p2;

endmodule
